// File: rtl/stage_instruction_decode.sv
// ---------------------------------------------------------------------------
// stage_instruction_decode
//
// Decode stage of the five-stage RV32I pipeline. It decodes the instruction
// held in the fetch->decode registers into datapath controls, reads operands
// from the 32x32 integer register file, and extends the immediate. The
// results are loaded into the decode->execute registers (ex_*).
//
// The register file is written from writeback. A read of the register being
// written in the same cycle returns the writeback data (write-through).
//
// Ports:
//   clk           in  1   single clock, rising edge
//   reset         in  1   asynchronous, active-low; clears regfile and ex_*
//   ex_clear      in  1   synchronous flush of ex_* (bubble), beats ex_stall
//   ex_stall      in  1   hold ex_*
//   de_instr      in  32  instruction from fetch
//   de_pc         in  32  PC of de_instr
//   de_pc_plus4   in  32  PC + 4 of de_instr
//   wb_reg_write  in  1   writeback write enable
//   wb_rd         in  5   writeback destination register
//   wb_result     in  32  writeback data
//   de_rs1/2      out 5   combinational source indices for the hazard unit
//   ex_rd1/2      out 32  registered source operands
//   ex_imm        out 32  registered sign-extended immediate
//   ex_pc         out 32  registered PC
//   ex_pc_plus4   out 32  registered PC + 4
//   ex_rs1/2, ex_rd out 5 registered register indices
//   ex_funct3     out 3   registered funct3
//   ex_reg_write, ex_mem_write, ex_jump, ex_branch,
//   ex_alu_src_a (1 = pc), ex_alu_src_b (1 = imm), ex_illegal  out 1
//   ex_result_src out 2   00 ALU, 01 memory, 10 pc+4
//   ex_alu_control out 4  ALU operation code
// ---------------------------------------------------------------------------
module stage_instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_clear,
  input  logic        ex_stall,
  input  logic [31:0] de_instr,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_pc_plus4,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc_plus4,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_jump,
  output logic        ex_branch,
  output logic        ex_alu_src_a,
  output logic        ex_alu_src_b,
  output logic        ex_illegal,
  output logic [1:0]  ex_result_src,
  output logic [3:0]  ex_alu_control
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrcA;
    logic        aluSrcB;
    logic        illegal;
    logic [1:0]  resultSrc;
    logic [3:0]  aluControl;
  } exRegs_t;

  logic [31:0] regs_q [32];
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [31:0] rd1Val, rd2Val;
  exRegs_t     ex_d, ex_q;

  assign opcode   = de_instr[6:0];
  assign funct3   = de_instr[14:12];
  assign funct7b5 = de_instr[30];
  assign de_rs1   = de_instr[19:15];
  assign de_rs2   = de_instr[24:20];

  assign immI = {{20{de_instr[31]}}, de_instr[31:20]};
  assign immS = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
  assign immB = {{19{de_instr[31]}}, de_instr[31], de_instr[7],
                 de_instr[30:25], de_instr[11:8], 1'b0};
  assign immU = {de_instr[31:12], 12'b0};
  assign immJ = {{11{de_instr[31]}}, de_instr[31], de_instr[19:12],
                 de_instr[20], de_instr[30:21], 1'b0};

  // Entry 0 is never written, so it stays zero after reset; reads of x0
  // are additionally forced to zero below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_reg_write && (wb_rd != 5'd0)) begin
      regs_q[wb_rd] <= wb_result;
    end
  end

  // Write-through: a same-cycle writeback to a source register wins over
  // the stored value, so no bypass is needed for the WB->ID distance.
  always_comb begin
    rd1Val = '0;
    if (de_rs1 != 5'd0) begin
      if (wb_reg_write && (wb_rd == de_rs1)) rd1Val = wb_result;
      else                                   rd1Val = regs_q[de_rs1];
    end
  end

  always_comb begin
    rd2Val = '0;
    if (de_rs2 != 5'd0) begin
      if (wb_reg_write && (wb_rd == de_rs2)) rd2Val = wb_result;
      else                                   rd2Val = regs_q[de_rs2];
    end
  end

  // Shared funct3 decode for R-type and I-ALU. Only R-type uses funct7[5]
  // to pick SUB; for shifts both use it to pick the arithmetic variant.
  function automatic logic [3:0] aluFromFunct(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       isR);
    logic [3:0] op;
    op = AluAdd;
    unique case (f3)
      3'b000:  op = (isR && f7b5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = f7b5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    ex_d            = '0;
    ex_d.rd1        = rd1Val;
    ex_d.rd2        = rd2Val;
    ex_d.pc         = de_pc;
    ex_d.pcPlus4    = de_pc_plus4;
    ex_d.rs1        = de_rs1;
    ex_d.rs2        = de_rs2;
    ex_d.rd         = de_instr[11:7];
    ex_d.funct3     = funct3;
    ex_d.resultSrc  = ResAlu;
    ex_d.aluControl = AluAdd;
    case (opcode)
      OpR: begin
        ex_d.regWrite   = 1'b1;
        ex_d.aluControl = aluFromFunct(funct3, funct7b5, 1'b1);
      end
      OpIAlu: begin
        ex_d.regWrite   = 1'b1;
        ex_d.aluSrcB    = 1'b1;
        ex_d.imm        = immI;
        ex_d.aluControl = aluFromFunct(funct3, funct7b5, 1'b0);
      end
      OpLoad: begin
        ex_d.regWrite  = 1'b1;
        ex_d.resultSrc = ResMem;
        ex_d.aluSrcB   = 1'b1;
        ex_d.imm       = immI;
      end
      OpStore: begin
        ex_d.memWrite = 1'b1;
        ex_d.aluSrcB  = 1'b1;
        ex_d.imm      = immS;
      end
      OpBr: begin
        ex_d.branch     = 1'b1;
        ex_d.aluControl = AluSub;
        ex_d.imm        = immB;
      end
      OpJal: begin
        ex_d.jump      = 1'b1;
        ex_d.regWrite  = 1'b1;
        ex_d.resultSrc = ResPc4;
        ex_d.aluSrcA   = 1'b1;
        ex_d.aluSrcB   = 1'b1;
        ex_d.imm       = immJ;
      end
      OpJalr: begin
        ex_d.jump      = 1'b1;
        ex_d.regWrite  = 1'b1;
        ex_d.resultSrc = ResPc4;
        ex_d.aluSrcB   = 1'b1;
        ex_d.imm       = immI;
      end
      OpLui: begin
        ex_d.regWrite   = 1'b1;
        ex_d.aluSrcB    = 1'b1;
        ex_d.imm        = immU;
        ex_d.aluControl = AluPassB;
      end
      OpAuipc: begin
        ex_d.regWrite = 1'b1;
        ex_d.aluSrcA  = 1'b1;
        ex_d.aluSrcB  = 1'b1;
        ex_d.imm      = immU;
      end
      default: begin
        // An all-zero word is a fetch bubble and decodes as a quiet NOP.
        ex_d.illegal = (de_instr != 32'd0);
      end
    endcase
  end

  // Decode->execute register: reset, then clear, then stall, then load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else if (ex_clear) begin
      ex_q <= '0;
    end else if (!ex_stall) begin
      ex_q <= ex_d;
    end
  end

  assign ex_rd1         = ex_q.rd1;
  assign ex_rd2         = ex_q.rd2;
  assign ex_imm         = ex_q.imm;
  assign ex_pc          = ex_q.pc;
  assign ex_pc_plus4    = ex_q.pcPlus4;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_rd          = ex_q.rd;
  assign ex_funct3      = ex_q.funct3;
  assign ex_reg_write   = ex_q.regWrite;
  assign ex_mem_write   = ex_q.memWrite;
  assign ex_jump        = ex_q.jump;
  assign ex_branch      = ex_q.branch;
  assign ex_alu_src_a   = ex_q.aluSrcA;
  assign ex_alu_src_b   = ex_q.aluSrcB;
  assign ex_illegal     = ex_q.illegal;
  assign ex_result_src  = ex_q.resultSrc;
  assign ex_alu_control = ex_q.aluControl;

endmodule

// File: tb/tb_stage_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_stage_instruction_decode
//
// Self-checking bench for stage_instruction_decode. A table of instruction
// vectors with hand-derived expected ex_* bundles is applied in a loop;
// hand-written sequences cover stall, clear, asynchronous reset and the
// register file contents after reset. Expected bundles are queued when
// stimulus is driven and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_stage_instruction_decode;

  logic        clk;
  logic        reset;
  logic        ex_clear;
  logic        ex_stall;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic [31:0] de_pc_plus4;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic [31:0] ex_pc_plus4;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write;
  logic        ex_mem_write;
  logic        ex_jump;
  logic        ex_branch;
  logic        ex_alu_src_a;
  logic        ex_alu_src_b;
  logic        ex_illegal;
  logic [1:0]  ex_result_src;
  logic [3:0]  ex_alu_control;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrcA;
    logic        aluSrcB;
    logic [3:0]  aluControl;
    logic        illegal;
  } exBundle_t;

  typedef struct {
    logic [31:0] instr;
    logic        wbWe;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    exBundle_t   exp;
  } vec_t;

  exBundle_t expQ[$];
  vec_t      vecs[16];
  int        applied;
  int        miscompares;

  stage_instruction_decode dut (
    .clk            (clk),
    .reset          (reset),
    .ex_clear       (ex_clear),
    .ex_stall       (ex_stall),
    .de_instr       (de_instr),
    .de_pc          (de_pc),
    .de_pc_plus4    (de_pc_plus4),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .de_rs1         (de_rs1),
    .de_rs2         (de_rs2),
    .ex_rd1         (ex_rd1),
    .ex_rd2         (ex_rd2),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_funct3      (ex_funct3),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_write   (ex_mem_write),
    .ex_jump        (ex_jump),
    .ex_branch      (ex_branch),
    .ex_alu_src_a   (ex_alu_src_a),
    .ex_alu_src_b   (ex_alu_src_b),
    .ex_illegal     (ex_illegal),
    .ex_result_src  (ex_result_src),
    .ex_alu_control (ex_alu_control)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls somewhere
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Builds an expected bundle; pc+4 follows from the pc the bench drives
  function automatic exBundle_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic [2:0] f3,
                                   input logic rw, input logic [1:0] rsrc,
                                   input logic mw, input logic j, input logic b,
                                   input logic sa, input logic sb,
                                   input logic [3:0] alu, input logic ill);
    exBundle_t e;
    e = '{rd1, rd2, imm, pc, pc + 32'd4, rs1, rs2, rd, f3, rw, rsrc, mw, j, b,
          sa, sb, alu, ill};
    return e;
  endfunction

  // Drives all stage inputs without touching the scoreboard
  task automatic driveInputs(input logic [31:0] instr, input logic [31:0] pc,
                             input logic we, input logic [4:0] rd,
                             input logic [31:0] data, input logic stall,
                             input logic clear);
    de_instr     = instr;
    de_pc        = pc;
    de_pc_plus4  = pc + 32'd4;
    wb_reg_write = we;
    wb_rd        = rd;
    wb_result    = data;
    ex_stall     = stall;
    ex_clear     = clear;
  endtask

  // Drives inputs and queues the bundle expected on ex_* after the next edge
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic we, input logic [4:0] rd,
                               input logic [31:0] data, input logic stall,
                               input logic clear, input exBundle_t exp);
    driveInputs(instr, pc, we, rd, data, stall, clear);
    expQ.push_back(exp);
  endtask

  // Pops the oldest expectation and compares it with the sampled ex_* bundle
  task automatic checkOutput(input string tag);
    exBundle_t act;
    exBundle_t exp;
    act = {ex_rd1, ex_rd2, ex_imm, ex_pc, ex_pc_plus4, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_reg_write, ex_result_src, ex_mem_write, ex_jump,
           ex_branch, ex_alu_src_a, ex_alu_src_b, ex_alu_control, ex_illegal};
    applied++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: no expectation queued, got %h", tag, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h required %h", tag, act, exp);
      end
    end
  endtask

  task automatic checkScalar(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  task automatic stepAndCheck(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Main sequence: reset, vector table, stall, clear, async reset, readback
  initial begin
    applied     = 0;
    miscompares = 0;
    reset       = 1'b0;
    driveInputs(32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Vector table: instr, writeback, expected bundle (pc 0x100 upwards)
    vecs[0]  = '{32'h000281B3, 1'b1, 5'd5, 32'hDEADBEEF,
                 mk(32'hDEADBEEF, 0, 0, 32'h100, 5, 0, 3, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0)};
    vecs[1]  = '{32'h40528233, 1'b1, 5'd0, 32'h12345678,
                 mk(32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h104, 5, 5, 4, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0001, 0)};
    vecs[2]  = '{32'h00500333, 1'b1, 5'd0, 32'h12345678,
                 mk(0, 32'hDEADBEEF, 0, 32'h108, 0, 5, 6, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0)};
    vecs[3]  = '{32'hFE208CE3, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 32'hFFFFFFF8, 32'h10C, 1, 2, 25, 0, 0, 2'b00, 0, 0, 1, 0, 0, 4'b0001, 0)};
    vecs[4]  = '{32'h001000EF, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 32'h00000800, 32'h110, 0, 1, 1, 0, 1, 2'b10, 0, 1, 0, 1, 1, 4'b0000, 0)};
    vecs[5]  = '{32'hABCDE3B7, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 32'hABCDE000, 32'h114, 27, 28, 7, 6, 1, 2'b00, 0, 0, 0, 0, 1, 4'b1010, 0)};
    vecs[6]  = '{32'hFFF28413, 1'b0, 5'd0, 32'h0,
                 mk(32'hDEADBEEF, 0, 32'hFFFFFFFF, 32'h118, 5, 31, 8, 0, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 0)};
    vecs[7]  = '{32'h4042D493, 1'b0, 5'd0, 32'h0,
                 mk(32'hDEADBEEF, 0, 32'h00000404, 32'h11C, 5, 4, 9, 5, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0111, 0)};
    vecs[8]  = '{32'h0082A503, 1'b0, 5'd0, 32'h0,
                 mk(32'hDEADBEEF, 0, 32'h8, 32'h120, 5, 8, 10, 2, 1, 2'b01, 0, 0, 0, 0, 1, 4'b0000, 0)};
    vecs[9]  = '{32'h00502623, 1'b0, 5'd0, 32'h0,
                 mk(0, 32'hDEADBEEF, 32'hC, 32'h124, 0, 5, 12, 2, 0, 2'b00, 1, 0, 0, 0, 1, 4'b0000, 0)};
    vecs[10] = '{32'h004280E7, 1'b0, 5'd0, 32'h0,
                 mk(32'hDEADBEEF, 0, 32'h4, 32'h128, 5, 4, 1, 0, 1, 2'b10, 0, 1, 0, 0, 1, 4'b0000, 0)};
    vecs[11] = '{32'h00001117, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 32'h00001000, 32'h12C, 0, 0, 2, 1, 1, 2'b00, 0, 0, 0, 1, 1, 4'b0000, 0)};
    vecs[12] = '{32'h00000000, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 0, 32'h130, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0)};
    vecs[13] = '{32'h0000007F, 1'b0, 5'd0, 32'h0,
                 mk(0, 0, 0, 32'h134, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 1)};
    vecs[14] = '{32'h0062C633, 1'b1, 5'd6, 32'h0F0F0F0F,
                 mk(32'hDEADBEEF, 32'h0F0F0F0F, 0, 32'h138, 5, 6, 12, 4, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0100, 0)};
    vecs[15] = '{32'h005336B3, 1'b0, 5'd0, 32'h0,
                 mk(32'h0F0F0F0F, 32'hDEADBEEF, 0, 32'h13C, 6, 5, 13, 3, 1, 2'b00, 0, 0, 0, 0, 0, 4'b1001, 0)};

    // Reset state before any clock edge
    #2;
    expQ.push_back('0);
    checkOutput("resetInit");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven decode checks
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].exp.pc, vecs[i].wbWe, vecs[i].wbRd,
                    vecs[i].wbData, 1'b0, 1'b0, vecs[i].exp);
      stepAndCheck($sformatf("vec%0d", i));
    end

    // Stall for three cycles while de_instr changes; a writeback during the
    // stall must still reach the register file
    applyStimulus(32'hFFF28413, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                  mk(32'hDEADBEEF, 0, 32'hFFFFFFFF, 32'h200, 5, 31, 8, 0, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 0));
    stepAndCheck("stallLoad");
    for (int k = 0; k < 3; k++) begin
      applyStimulus((k == 0) ? 32'h0000007F : ((k == 1) ? 32'hABCDE3B7 : 32'h40528233),
                    32'h204 + 32'(4 * k), (k == 0), 5'd20, 32'hCAFEF00D, 1'b1, 1'b0,
                    mk(32'hDEADBEEF, 0, 32'hFFFFFFFF, 32'h200, 5, 31, 8, 0, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 0));
      stepAndCheck($sformatf("stallHold%0d", k));
    end
    applyStimulus(32'h000A0033, 32'h210, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                  mk(32'hCAFEF00D, 0, 0, 32'h210, 20, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0));
    stepAndCheck("writeDuringStall");

    // Clear together with stall: clear wins and inserts a bubble
    applyStimulus(32'hABCDE3B7, 32'h214, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, '0);
    stepAndCheck("clearWithStall");

    // Asynchronous reset in the middle of a cycle
    driveInputs(32'hFFF28413, 32'h218, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    expQ.push_back('0);
    checkOutput("resetAsync");
    checkScalar("deRs1InReset", 32'(de_rs1), 32'd5);
    checkScalar("deRs2InReset", 32'(de_rs2), 32'd31);
    #2;
    reset = 1'b1;
    expQ.push_back(mk(0, 0, 32'hFFFFFFFF, 32'h218, 5, 31, 8, 0, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 0));
    stepAndCheck("afterReset");

    // Every writable register reads zero after reset
    for (int r = 1; r < 32; r++) begin
      applyStimulus((32'(r) << 20) | (32'(r) << 15) | 32'h33, 32'h300 + 32'(4 * r),
                    1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    mk(0, 0, 0, 32'h300 + 32'(4 * r), 5'(r), 5'(r), 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0));
      stepAndCheck($sformatf("readZeroX%0d", r));
    end

    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_instruction_decode.md
# stage_instruction_decode

Second stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. Consumes the fetch→decode registers (`de_instr`, `de_pc`, `de_pc_plus4`) and decodes the instruction into control signals. It owns the 32×32 integer register file, written from writeback and read with same-cycle write-through. It extends immediates and drives the decode→execute pipeline registers (`ex_*`), which honour `ex_clear` and `ex_stall` from the hazard unit.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears register file and every `ex_*` output.
- `ex_clear` in 1: synchronous flush of decode→execute registers (bubble insert).
- `ex_stall` in 1: hold decode→execute registers.
- `de_instr`, `de_pc`, `de_pc_plus4` in 32 each: from fetch stage registers.
- `wb_reg_write` in 1: writeback write enable.
- `wb_rd` in 5: writeback destination.
- `wb_result` in 32: writeback data.
- `de_rs1`, `de_rs2` out 5: combinational `de_instr[19:15]`, `[24:20]`, for the hazard unit.
- `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_pc`, `ex_pc_plus4` out 32: registered operands, immediate, and PCs.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5: registered register indices.
- `ex_funct3` out 3: registered, used by branch compare and load/store sizing.
- `ex_reg_write`, `ex_mem_write`, `ex_jump`, `ex_branch`, `ex_alu_src_a`, `ex_alu_src_b`, `ex_illegal` out 1: registered controls.
- `ex_result_src` out 2: 00 ALU, 01 memory, 10 pc+4.
- `ex_alu_control` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.

## Operation
- **Register file.**
  - x0 reads 0 and ignores writes.
  - Write occurs at the rising edge when `wb_reg_write && wb_rd != 0`.
  - Write-through: if the read index equals `wb_rd`, is nonzero, and `wb_reg_write` is high, the read returns `wb_result` in the same cycle.
- **Decode by opcode.**
  - R 0110011: reg_write; ALU op from funct3/funct7[5].
  - I-ALU 0010011: reg_write, src_b=imm. SRAI is selected by funct7[5]. funct3=000 is always ADD; there is no SUBI.
  - Load 0000011: reg_write, result_src=01, ADD, src_b=imm.
  - Store 0100011: mem_write, ADD, src_b=imm.
  - Branch 1100011: branch, SUB, src_b=rs2.
  - JAL 1101111: jump, reg_write, result_src=10, src_a=pc, src_b=imm, ADD.
  - JALR 1100111: jump, reg_write, result_src=10, src_a=rs1, src_b=imm, ADD.
  - LUI 0110111: reg_write, src_b=imm, PASSB.
  - AUIPC 0010111: reg_write, src_a=pc, src_b=imm, ADD.
- **Immediates.** All immediates are sign-extended from bit 31.
  - I: `[31:20]`.
  - S: `[31:25|11:7]`.
  - B: `[31|7|30:25|11:8|0]`.
  - U: `[31:12]<<12`.
  - J: `[31|19:12|20|30:21|0]`.
- **Non-RV32I opcodes.**
  - `de_instr == 0` (fetch bubble) decodes as NOP: all controls 0, `ex_illegal`=0.
  - Any other unlisted opcode: all controls 0, `ex_illegal`=1.
- **Pipeline register priority:** reset > `ex_clear` > `ex_stall` > load.
  - `ex_clear` zeroes every `ex_*` output.
  - `ex_stall` holds all `ex_*` outputs.

## Timing
- Decode is combinational within the cycle; results appear on `ex_*` one cycle after `de_instr` is presented.
- A register file write at edge N is visible to decode in cycle N via write-through, and from storage afterwards.
- Register file writes proceed regardless of `ex_stall` and `ex_clear`.
- `ex_clear` and `ex_stall` asserted together: clear wins.
- Reset asserted mid-operation:
  - immediately (asynchronously) zeroes all `ex_*` outputs and all 31 writable registers;
  - deassertion takes effect at the next rising edge;
  - `de_rs1`/`de_rs2` remain combinational from `de_instr`.

## Test plan
- **Reset.** Pulse `reset` low mid-stream → all `ex_*` = 0 immediately, before the next clock edge. Afterwards, reads of x1..x31 return 0.
- **Write-through.** `wb_reg_write`=1, `wb_rd`=5, `wb_result`=0xDEADBEEF while decoding `add x3,x5,x0` (0x000281B3) → next cycle `ex_rd1`=0xDEADBEEF, `ex_rd2`=0, `ex_rd`=3, `ex_alu_control`=0000, `ex_reg_write`=1.
- **x0 write ignored.** Write x0 with 0x12345678, then read x0 → 0.
- **Immediates.**
  - `beq x1,x2,-8` (0xFE208CE3) → `ex_imm`=0xFFFFFFF8, `ex_branch`=1, `ex_alu_control`=0001.
  - `jal x1,2048` (0x001000EF) → `ex_imm`=0x00000800, `ex_jump`=1, `ex_result_src`=10.
  - `lui x7,0xABCDE` → `ex_imm`=0xABCDE000, PASSB.
- **Stall and clear.**
  - `ex_stall`=1 for 3 cycles while `de_instr` changes → `ex_*` held.
  - `ex_clear`=1 with `ex_stall`=1 → all `ex_*` = 0.
  - `de_instr`=0 → NOP with `ex_illegal`=0.
  - `de_instr`=0x0000007F → `ex_illegal`=1, all other controls 0.
